// File: rtl/lcd_gen2_pkg.sv
// Shared command codes and controller state encoding for lcd_ctrl_gen2.
package lcd_gen2_pkg;

  localparam logic [3:0] CMD_WRITE   = 4'd0;
  localparam logic [3:0] CMD_UP      = 4'd1;
  localparam logic [3:0] CMD_DOWN    = 4'd2;
  localparam logic [3:0] CMD_LEFT    = 4'd3;
  localparam logic [3:0] CMD_RIGHT   = 4'd4;
  localparam logic [3:0] CMD_MAX     = 4'd5;
  localparam logic [3:0] CMD_MIN     = 4'd6;
  localparam logic [3:0] CMD_AVG     = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW = 4'd8;
  localparam logic [3:0] CMD_ROT_CW  = 4'd9;
  localparam logic [3:0] CMD_MIR_X   = 4'd10;
  localparam logic [3:0] CMD_MIR_Y   = 4'd11;
  localparam logic [3:0] CMD_CENTER  = 4'd12;
  localparam logic [3:0] CMD_LOAD    = 4'd13;
  localparam logic [3:0] CMD_NOP14   = 4'd14;
  localparam logic [3:0] CMD_NOP15   = 4'd15;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator. Pixel order everywhere: 0=tl, 1=tr, 2=bl, 3=br.
// Commands that do not modify the window pass it through unchanged.
module lcd_win_alu #(
  parameter int DW = 8
) (
  input  logic [3:0]         cmd,
  input  logic [3:0][DW-1:0] win_i,
  output logic [3:0][DW-1:0] win_o
);
  import lcd_gen2_pkg::*;

  logic [DW-1:0] mx;
  logic [DW-1:0] mn;
  logic [DW+1:0] sum;

  // Window reductions: max, min and a sum two bits wider than a pixel.
  always_comb begin
    mx  = win_i[0];
    mn  = win_i[0];
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_i[i] > mx) mx = win_i[i];
      if (win_i[i] < mn) mn = win_i[i];
      sum = sum + {2'b00, win_i[i]};
    end
  end

  // Replacement pixels; concatenations list br first (index 3 down to 0).
  always_comb begin
    win_o = win_i;
    case (cmd)
      CMD_MAX:     win_o = {4{mx}};
      CMD_MIN:     win_o = {4{mn}};
      CMD_AVG:     win_o = {4{sum[DW+1:2]}};
      CMD_ROT_CCW: win_o = {win_i[2], win_i[0], win_i[3], win_i[1]};
      CMD_ROT_CW:  win_o = {win_i[1], win_i[3], win_i[0], win_i[2]};
      CMD_MIR_X:   win_o = {win_i[1], win_i[0], win_i[3], win_i[2]};
      CMD_MIR_Y:   win_o = {win_i[2], win_i[3], win_i[0], win_i[1]};
      default:     win_o = win_i;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen2.sv
// LCD image controller: loads a frame from ROM into a local buffer, applies
// cursor/window commands, and streams the buffer out to RAM on request.
module lcd_ctrl_gen2 #(
  parameter  int DW = 8,
  parameter  int W  = 8,
  parameter  int H  = 8,
  localparam int N  = W * H,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          rom_rd,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q,
  output logic          ram_valid,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          busy,
  output logic          done
);
  import lcd_gen2_pkg::*;

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam logic [XW-1:0] X_MIN  = XW'(1);
  localparam logic [XW-1:0] X_MAX  = XW'(W - 1);
  localparam logic [XW-1:0] X_MID  = XW'(W / 2);
  localparam logic [YW-1:0] Y_MIN  = YW'(1);
  localparam logic [YW-1:0] Y_MAX  = YW'(H - 1);
  localparam logic [YW-1:0] Y_MID  = YW'(H / 2);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic          rom_rd_q, rom_rd_d;
  logic [AW-1:0] rom_a_q, rom_a_d;
  logic          cap_vld_q, cap_vld_d;   // rom_q holds a pixel this cycle
  logic [AW-1:0] cap_a_q, cap_a_d;       // address that pixel belongs to
  logic          ram_valid_q, ram_valid_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0] ram_d_q, ram_d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [DW-1:0] img_q [N];
  logic [DW-1:0] img_d [N];

  logic [3:0][AW-1:0] win_a;
  logic [3:0][DW-1:0] win_px;
  logic [3:0][DW-1:0] win_new;
  logic               win_we;

  // Window addresses around the cursor (cursor is the lower-right pixel).
  always_comb begin
    win_a[0] = {y_q - Y_MIN, x_q - X_MIN};
    win_a[1] = {y_q - Y_MIN, x_q};
    win_a[2] = {y_q, x_q - X_MIN};
    win_a[3] = {y_q, x_q};
    for (int i = 0; i < 4; i++) win_px[i] = img_q[win_a[i]];
  end

  assign win_we = (cmd_q >= CMD_MAX) && (cmd_q <= CMD_MIR_Y);

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd   (cmd_q),
    .win_i (win_px),
    .win_o (win_new)
  );

  // Next-state logic for the LOAD / WAIT / EXEC / WRITE sequencer and buffer.
  always_comb begin
    state_d     = state_q;
    rom_rd_d    = rom_rd_q;
    rom_a_d     = rom_a_q;
    cap_vld_d   = rom_rd_q;
    cap_a_d     = rom_a_q;
    ram_valid_d = ram_valid_q;
    ram_a_d     = ram_a_q;
    ram_d_d     = ram_d_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    cmd_d       = cmd_q;
    img_d       = img_q;
    if (cap_vld_q) img_d[cap_a_q] = rom_q;
    case (state_q)
      ST_LOAD: begin
        if (rom_rd_q) begin
          if (rom_a_q == A_LAST) rom_rd_d = 1'b0;
          else                   rom_a_d  = rom_a_q + A_ONE;
        end else if (cap_vld_q) begin
          // last pixel lands this edge
          state_d = ST_WAIT;
          busy_d  = 1'b0;
        end else begin
          rom_rd_d = 1'b1;
          rom_a_d  = '0;
        end
      end
      ST_WAIT: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WAIT;
        busy_d  = 1'b0;
        case (cmd_q)
          CMD_WRITE: begin
            state_d     = ST_WRITE;
            busy_d      = 1'b1;
            ram_valid_d = 1'b1;
            ram_a_d     = '0;
            ram_d_d     = img_q[0];
          end
          CMD_UP:     if (y_q != Y_MIN) y_d = y_q - Y_MIN;
          CMD_DOWN:   if (y_q != Y_MAX) y_d = y_q + Y_MIN;
          CMD_LEFT:   if (x_q != X_MIN) x_d = x_q - X_MIN;
          CMD_RIGHT:  if (x_q != X_MAX) x_d = x_q + X_MIN;
          CMD_CENTER: begin
            x_d = X_MID;
            y_d = Y_MID;
          end
          CMD_LOAD: begin
            state_d  = ST_LOAD;
            busy_d   = 1'b1;
            rom_rd_d = 1'b0;
            rom_a_d  = '0;
          end
          default: ;
        endcase
        if (win_we) begin
          for (int i = 0; i < 4; i++) img_d[win_a[i]] = win_new[i];
        end
      end
      ST_WRITE: begin
        if (ram_a_q == A_LAST) begin
          ram_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          ram_a_d = ram_a_q + A_ONE;
          ram_d_d = img_q[ram_a_q + A_ONE];
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control registers; reset parks in LOAD with the ROM port idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= '0;
      cap_vld_q   <= 1'b0;
      cap_a_q     <= '0;
      ram_valid_q <= 1'b0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      x_q         <= X_MID;
      y_q         <= Y_MID;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      rom_rd_q    <= rom_rd_d;
      rom_a_q     <= rom_a_d;
      cap_vld_q   <= cap_vld_d;
      cap_a_q     <= cap_a_d;
      ram_valid_q <= ram_valid_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmd_q       <= cmd_d;
    end
  end

  // Image buffer: plain storage, contents undefined after reset.
  always_ff @(posedge clk) begin
    img_q <= img_d;
  end

  assign rom_rd    = rom_rd_q;
  assign rom_a     = rom_a_q;
  assign ram_valid = ram_valid_q;
  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/lcd_ctrl_gen2.md
LCD_CTRL_GEN2 -- requirements
Module: lcd_ctrl_gen2

Interface
REQ-001 SHALL have parameter DW, default 8: pixel width in bits.
REQ-002 SHALL have parameter W, default 8: image width in pixels; power of 2, at least 4.
REQ-003 SHALL have parameter H, default 8: image height in pixels; power of 2, at least 4.
REQ-004 SHALL have derived local parameters N = W*H and AW = log2(N).
REQ-005 SHALL have port clk, input, 1 bit: clock; all registers update on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port cmd, input, 4 bits: command code.
REQ-008 SHALL have port cmd_valid, input, 1 bit: cmd qualifier.
REQ-009 SHALL have port rom_rd, output, 1 bit: ROM read enable.
REQ-010 SHALL have port rom_a, output, AW bits: ROM address.
REQ-011 SHALL have port rom_q, input, DW bits: ROM data, valid one cycle after rom_a.
REQ-012 SHALL have port ram_valid, output, 1 bit: RAM write strobe.
REQ-013 SHALL have port ram_a, output, AW bits: RAM write address.
REQ-014 SHALL have port ram_d, output, DW bits: RAM write data.
REQ-015 SHALL have port busy, output, 1 bit: 1 means the block ignores commands.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a frame write.

Function
REQ-017 SHALL hold an internal N x DW image buffer; pixel (x,y) is stored at address y*W+x.
REQ-018 SHALL use states LOAD, WAIT, EXEC, WRITE; LOAD is entered at the first rising edge after reset is released.
REQ-019 LOAD SHALL drive rom_rd=1 and rom_a=0..N-1, one address per cycle, and capture rom_q into buffer[rom_a of the previous cycle].
REQ-020 LOAD SHALL drop rom_rd after address N-1, capture the last pixel, then enter WAIT with busy=0; busy falls exactly N+2 cycles after reset release.
REQ-021 The cursor (x,y) SHALL mark the lower-right pixel of the 2x2 window {(x-1,y-1),(x,y-1),(x-1,y),(x,y)}; x ranges 1..W-1, y ranges 1..H-1, initial value (W/2,H/2).
REQ-022 In WAIT, cmd_valid=1 SHALL latch cmd, raise busy and enter EXEC; cmd_valid while busy=1 SHALL be ignored.
REQ-023 EXEC SHALL last exactly one cycle, apply the latched cmd, then return to WAIT with busy=0; cmd 0 is the exception and goes to WRITE.
REQ-024 cmd 1/2/3/4 SHALL move the cursor y-1 / y+1 / x-1 / x+1; at a range limit the cursor saturates and does not move.
REQ-025 cmd 5/6 SHALL write the window max / min to all 4 window pixels.
REQ-026 cmd 7 SHALL write floor(sum/4) to all 4 window pixels; the sum is DW+2 bits wide so no overflow occurs.
REQ-027 cmd 8 SHALL rotate the window counter-clockwise; cmd 9 SHALL rotate it clockwise.
REQ-028 cmd 10 SHALL mirror the window about X (swap rows); cmd 11 SHALL mirror it about Y (swap columns).
REQ-029 cmd 12 SHALL restore the cursor to (W/2,H/2).
REQ-030 cmd 13 SHALL re-enter LOAD; the full LOAD sequence then runs again.
REQ-031 cmd 14 and cmd 15 SHALL be no-ops that still cost the one EXEC cycle.
REQ-032 WRITE SHALL drive ram_valid=1 with ram_a=0..N-1 ascending for N consecutive cycles, with ram_d=buffer[ram_a].
REQ-033 After the last WRITE beat, the block SHALL drop ram_valid, pulse done for 1 cycle, and return to WAIT with busy=0; buffer and cursor are preserved, so repeated writes are allowed.
REQ-034 ram_a and ram_d SHALL hold their last values while ram_valid=0.

Reset
REQ-035 reset SHALL force: rom_rd=0, rom_a=0, ram_valid=0, ram_a=0, ram_d=0, busy=1, done=0, cursor=(W/2,H/2), latched cmd=0.
REQ-036 Buffer contents after reset SHALL be don't-care; buffer writes are not reset.
REQ-037 reset asserted during LOAD, EXEC or WRITE SHALL abort the operation immediately (asynchronously); the sequence restarts with LOAD after release.

Structure
REQ-038 Package lcd_gen2_pkg SHALL contain the cmd code constants (0..15) and the state encoding.
REQ-039 Sub-module lcd_win_alu (combinational, parameter DW) SHALL take the 4 window pixels and cmd and return the 4 replacement pixels.

Verification (W=H=8, DW=8, ROM pixel[i]=i)
REQ-040 Reset, then release -> rom_a steps 0..63 once each, busy=0 at cycle 66, a WRITE dump shows ram_d[i]=i.
REQ-041 cmd 5 at the default cursor (4,4) on pixels 27,28,35,36 -> all four read 36, all other addresses unchanged.
REQ-042 cmd 12, then 3x cmd 1 and 3x cmd 3 (cursor reaches (1,1)), then cmd 1 and cmd 3 again -> cursor stays (1,1); then cmd 9 on pixels 0,1,8,9 -> addr0=8, addr1=0, addr8=9, addr9=1.
REQ-043 cmd 7 on a window of 1,2,2,2 -> all 1; cmd 7 on a window of 255,255,255,255 -> all 255.
REQ-044 cmd_valid held high during EXEC and WRITE -> only the first command takes effect; two cmd 0 issued back-to-back -> two identical 64-beat streams and two single-cycle done pulses.
REQ-045 reset asserted at WRITE beat 20 -> ram_valid=0 and busy=1 within the same cycle; after release a fresh LOAD starts at rom_a=0.
